pcie_ltssm_polling: RTL
=======================

// Module: pcie_ltssm_polling
// PURPOSE
// - Polling sub-state machine directly upstream of the top-level LTSSM; produces its polling_complete/polling_invalid.
// - Drives Polling.Active (TS1 transmit) and Polling.Configuration (TS2 transmit).
// - Counts transmitted ordered sets and consecutive received ordered sets from the single-lane RX decoder.
// - Enforces the polling timeouts.
// PARAMETERS
// TX_TS1_MIN   1024     TS1s accepted by TX before Active may exit
// TX_TS2_MIN   16       TS2s accepted by TX (after first RX TS2) before Config may exit
// RX_CONSEC    8        consecutive qualifying RX ordered sets required
// T_ACTIVE     6000000  Polling.Active timeout, clk cycles (24 ms @ 250 MHz)
// T_CONFIG     12000000 Polling.Configuration timeout, clk cycles (48 ms @ 250 MHz)
// CNT_W        11       TX/RX counter width; must hold max(TX_TS1_MIN,TX_TS2_MIN,RX_CONSEC)
// TMR_W        24       timer width; must hold max(T_ACTIVE,T_CONFIG)
// PORTS
// clk              in  1  clock
// reset_n          in  1  asynchronous active-low reset
// start            in  1  1-cycle pulse from LTSSM on entering POLLING
// abort            in  1  LTSSM left POLLING (init/reset); return to IDLE silently
// rx_ts1_valid     in  1  1-cycle strobe: good TS1 received
// rx_ts2_valid     in  1  1-cycle strobe: good TS2 received
// rx_os_other      in  1  1-cycle strobe: any other ordered set / bad TS received
// tx_os_ready      in  1  TX framer accepts the requested ordered set this cycle
// tx_ts1_req       out 1  request TS1 transmission
// tx_ts2_req       out 1  request TS2 transmission
// polling_complete out 1  1-cycle pulse: Polling succeeded (LTSSM -> CONFIG)
// polling_invalid  out 1  1-cycle pulse: Polling timed out (LTSSM -> DETECT)
// busy             out 1  high in ACTIVE or CFG
// BEHAVIOUR
// - States: IDLE, ACTIVE, CFG, DONE, FAIL.
// - Reset: state=IDLE, all counters/timer/flags = 0, all outputs 0.
// - Decodes (registered state):
//   tx_ts1_req = (state==ACTIVE); tx_ts2_req = (state==CFG).
//   polling_complete = (state==DONE); polling_invalid = (state==FAIL); busy = ACTIVE|CFG.
// - Priority each cycle: abort > start > state logic.
//   abort: state=IDLE, counters cleared, no pulse.
//   start from any state: state=ACTIVE; tx_cnt, rx_cnt, timer, ts2_seen cleared.
// - TX handshake: an OS is sent on every edge where req && tx_os_ready.
//   tx_cnt increments on that edge, saturating at its threshold.
//   In CFG, tx_cnt counts only while ts2_seen=1.
// - ts2_seen: set on the first rx_ts2_valid in CFG; counted TS2s begin the cycle after it is set.
// - RX in ACTIVE: rx_ts1_valid XOR rx_ts2_valid -> rx_cnt+1 (saturate at RX_CONSEC).
//   rx_os_other, or ts1 and ts2 both high -> rx_cnt=0.
// - RX in CFG: rx_ts2_valid alone -> rx_cnt+1 (saturate).
//   rx_ts1_valid, rx_os_other, or both strobes -> rx_cnt=0.
//   rx_os_other together with a TS strobe -> reset wins.
// - Timer: cleared on entry to ACTIVE/CFG; +1 every cycle in those states.
// - Exit conditions use registered counter values; an event at edge k is acted on at edge k+1 at the earliest.
// - ACTIVE exit: tx_cnt>=TX_TS1_MIN && rx_cnt>=RX_CONSEC -> CFG.
//   On entry to CFG: tx_cnt, rx_cnt, timer cleared, ts2_seen=0.
// - ACTIVE timeout: else if timer==T_ACTIVE-1 -> FAIL.
// - CFG exit: ts2_seen && tx_cnt>=TX_TS2_MIN && rx_cnt>=RX_CONSEC -> DONE.
// - CFG timeout: else if timer==T_CONFIG-1 -> FAIL.
// - Success beats timeout when both hold on the same edge.
// - DONE and FAIL last exactly 1 cycle, then IDLE. start/abort still take priority in those cycles.
// - IDLE ignores all RX/TX inputs; req outputs stay low.
// - Reset asserted mid-operation: immediate IDLE, no pulse.
// TESTING (TX_TS1_MIN=4, TX_TS2_MIN=3, RX_CONSEC=2, T_ACTIVE=50, T_CONFIG=60)
// 1 Nominal: start, ready=1, two TS1 strobes at cycles 2,3 -> CFG after 4th TS1; TS2 strobes each cycle -> one polling_complete pulse, busy drops.
// 2 Active timeout: start, ready=0, no RX -> polling_invalid pulse exactly 50 cycles after ACTIVE entry, tx_ts1_req low afterwards.
// 3 Consecutive break: ACTIVE, TS1, rx_os_other, TS1 -> rx_cnt=1, no exit; one more TS1 -> CFG.
// 4 CFG TS2 gating: TS1s received in CFG keep rx_cnt=0 and ts2_seen=0; tx_cnt stays 0 until the first RX TS2.
// 5 Abort/restart: abort during CFG -> IDLE next cycle, no pulse; start during ACTIVE at timer=40 -> timer restarts, timeout 50 cycles later.
// 6 Tie: success and timeout on the same edge (rx_cnt reaches 2 at timer=59) -> polling_complete, not polling_invalid.

Source files
------------

// File: rtl/pcie_ltssm_polling.sv
// rtl/pcie_ltssm_polling.sv - PCIe LTSSM Polling sub-state machine (Active / Configuration)
module pcie_ltssm_polling #(
  parameter int TX_TS1_MIN = 1024,
  parameter int TX_TS2_MIN = 16,
  parameter int RX_CONSEC  = 8,
  parameter int T_ACTIVE   = 6000000,
  parameter int T_CONFIG   = 12000000,
  parameter int CNT_W      = 11,
  parameter int TMR_W      = 24
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  input  logic rx_ts1_valid,
  input  logic rx_ts2_valid,
  input  logic rx_os_other,
  input  logic tx_os_ready,
  output logic tx_ts1_req,
  output logic tx_ts2_req,
  output logic polling_complete,
  output logic polling_invalid,
  output logic busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_CFG    = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  // Thresholds pre-sized to the counter/timer widths so compares stay width-clean.
  localparam logic [CNT_W-1:0] TS1_MIN_C = CNT_W'(TX_TS1_MIN);
  localparam logic [CNT_W-1:0] TS2_MIN_C = CNT_W'(TX_TS2_MIN);
  localparam logic [CNT_W-1:0] RX_MIN_C  = CNT_W'(RX_CONSEC);
  localparam logic [TMR_W-1:0] T_ACT_END = TMR_W'(T_ACTIVE - 1);
  localparam logic [TMR_W-1:0] T_CFG_END = TMR_W'(T_CONFIG - 1);

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
  logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
  logic [TMR_W-1:0] timer_q,    timer_d;
  logic             ts2_seen_q, ts2_seen_d;

  // RX qualification per sub-state; any disqualifying strobe wins over a good one.
  logic active_rx_clr, active_rx_inc;
  logic cfg_rx_clr,    cfg_rx_inc;
  logic active_exit,   cfg_exit;

  // Qualify RX strobes and evaluate exit conditions on registered counters.
  always_comb begin
    active_rx_clr = rx_os_other || (rx_ts1_valid && rx_ts2_valid);
    active_rx_inc = rx_ts1_valid ^ rx_ts2_valid;
    cfg_rx_clr    = rx_os_other || rx_ts1_valid;
    cfg_rx_inc    = rx_ts2_valid;
    active_exit   = (tx_cnt_q >= TS1_MIN_C) && (rx_cnt_q >= RX_MIN_C);
    cfg_exit      = ts2_seen_q && (tx_cnt_q >= TS2_MIN_C) && (rx_cnt_q >= RX_MIN_C);
  end

  // Next-state and counter update; abort beats start beats the sub-state logic.
  always_comb begin
    state_d    = state_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    timer_d    = timer_q;
    ts2_seen_d = ts2_seen_q;

    if (abort) begin
      state_d    = ST_IDLE;
      tx_cnt_d   = '0;
      rx_cnt_d   = '0;
      timer_d    = '0;
      ts2_seen_d = 1'b0;
    end else if (start) begin
      state_d    = ST_ACTIVE;
      tx_cnt_d   = '0;
      rx_cnt_d   = '0;
      timer_d    = '0;
      ts2_seen_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          timer_d = timer_q + 1'b1;
          // TS1 request is always up here, so ready alone marks a sent OS.
          if (tx_os_ready && (tx_cnt_q < TS1_MIN_C)) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
          if (active_rx_clr) begin
            rx_cnt_d = '0;
          end else if (active_rx_inc && (rx_cnt_q < RX_MIN_C)) begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
          // Success is checked first so it wins a tie with the timeout.
          if (active_exit) begin
            state_d    = ST_CFG;
            tx_cnt_d   = '0;
            rx_cnt_d   = '0;
            timer_d    = '0;
            ts2_seen_d = 1'b0;
          end else if (timer_q == T_ACT_END) begin
            state_d = ST_FAIL;
          end
        end

        ST_CFG: begin
          timer_d = timer_q + 1'b1;
          if (rx_ts2_valid) begin
            ts2_seen_d = 1'b1;
          end
          // Sent TS2s only count once a TS2 has been heard from the partner.
          if (ts2_seen_q && tx_os_ready && (tx_cnt_q < TS2_MIN_C)) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
          if (cfg_rx_clr) begin
            rx_cnt_d = '0;
          end else if (cfg_rx_inc && (rx_cnt_q < RX_MIN_C)) begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
          if (cfg_exit) begin
            state_d = ST_DONE;
          end else if (timer_q == T_CFG_END) begin
            state_d = ST_FAIL;
          end
        end

        ST_DONE, ST_FAIL: begin
          state_d    = ST_IDLE;
          tx_cnt_d   = '0;
          rx_cnt_d   = '0;
          timer_d    = '0;
          ts2_seen_d = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and timer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      timer_q    <= '0;
      ts2_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      timer_q    <= timer_d;
      ts2_seen_q <= ts2_seen_d;
    end
  end

  // Outputs are pure decodes of the registered state.
  always_comb begin
    tx_ts1_req       = (state_q == ST_ACTIVE);
    tx_ts2_req       = (state_q == ST_CFG);
    polling_complete = (state_q == ST_DONE);
    polling_invalid  = (state_q == ST_FAIL);
    busy             = (state_q == ST_ACTIVE) || (state_q == ST_CFG);
  end

endmodule
